// File: rtl/fetch_pkg.sv
// fetch_cache_mo shared types and defaults.
// FSM encoding, NOP word and default widths.
package fetch_pkg;

  localparam int DATA_W_D       = 32;
  localparam int ADDR_W_D       = 32;
  localparam int CACHE_ADDR_W_D = 25;
  localparam int IDX_W_D        = 21;
  localparam int MAX_OUTST_D    = 4;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fsm_e;

endpackage

// File: rtl/fetch_cache_mo_if.sv
// Read-only instruction cache bus.
// master = fetch engine, slave = cache.
interface fetch_cache_mo_if
  import fetch_pkg::*;
#(
  parameter int DATA_W       = DATA_W_D,
  parameter int CACHE_ADDR_W = CACHE_ADDR_W_D
);

  logic [CACHE_ADDR_W-1:0] o_p_addr;
  logic                    o_p_read;
  logic                    o_p_write;
  logic [DATA_W/8-1:0]     o_p_byte_en;
  logic [DATA_W-1:0]       o_p_writedata;
  logic [DATA_W-1:0]       i_p_readdata;
  logic                    i_p_readdata_valid;
  logic                    i_p_waitrequest;

  modport master (
    output o_p_addr, o_p_read, o_p_write,
    output o_p_byte_en, o_p_writedata,
    input  i_p_readdata, i_p_readdata_valid,
    input  i_p_waitrequest
  );

  modport slave (
    input  o_p_addr, o_p_read, o_p_write,
    input  o_p_byte_en, o_p_writedata,
    output i_p_readdata, i_p_readdata_valid,
    output i_p_waitrequest
  );

endinterface

// File: rtl/fetch_rsp_buf.sv
// Circular response buffer for returned words.
// Clear wins over push/pop; pointers wrap at DEPTH.
module fetch_rsp_buf
  import fetch_pkg::*;
#(
  parameter  int DEPTH = MAX_OUTST_D,
  parameter  int WIDTH = DATA_W_D,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  assign data_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= WIDTH'(INST_NOP);
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i)
        rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/fetch_cache_mo.sv
// Multi-outstanding instruction fetch engine.
// Issues up to MAX_OUTST reads, buffers words, drops stale ones.
module fetch_cache_mo
  import fetch_pkg::*;
#(
  parameter int DATA_W       = DATA_W_D,
  parameter int ADDR_W       = ADDR_W_D,
  parameter int CACHE_ADDR_W = CACHE_ADDR_W_D,
  parameter int IDX_W        = IDX_W_D,
  parameter int MAX_OUTST    = MAX_OUTST_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_flag_i,
  input  logic              flush_i,
  input  logic              jtag_reset_flag_i,
  fetch_cache_mo_if.master  cache,
  input  logic [ADDR_W-1:0] addr_fifo_r,
  input  logic              addr_fifo_empty,
  output logic              addr_fifo_ren,
  input  logic              inst_fifo_full,
  output logic [DATA_W-1:0] inst_fifo_r,
  output logic              inst_fifo_wen,
  output logic              inst_fifo_rstn
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  // repeated kills can stack stale reads beyond one window
  localparam int DW = CW + 2;

  logic          kill;
  logic          accept;
  logic          rsp;
  logic          dropping;
  logic          rsp_live;
  logic [CW-1:0] outst_q, outst_d;
  logic [DW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_cnt;
  logic [CW:0]   occ;
  fsm_e          state_q;
  logic          rstn_q;
  logic          unused_addr;

  assign kill = jump_flag_i | flush_i | jtag_reset_flag_i;
  assign occ  = {1'b0, outst_q} + {1'b0, buf_cnt};

  assign cache.o_p_read = ~addr_fifo_empty & ~kill
                        & (occ < (CW+1)'(MAX_OUTST));
  assign cache.o_p_addr      = CACHE_ADDR_W'(addr_fifo_r[IDX_W+1:2]);
  assign cache.o_p_write     = 1'b0;
  assign cache.o_p_byte_en   = '0;
  assign cache.o_p_writedata = '0;

  assign unused_addr = ^{addr_fifo_r[ADDR_W-1:IDX_W+2],
                         addr_fifo_r[1:0]};

  assign accept        = cache.o_p_read & ~cache.i_p_waitrequest;
  assign addr_fifo_ren = accept;

  assign rsp      = cache.i_p_readdata_valid;
  assign dropping = rsp & (drop_q != '0);
  assign rsp_live = rsp & ~dropping;

  assign inst_fifo_wen  = (buf_cnt != '0) & ~inst_fifo_full & ~kill;
  assign inst_fifo_rstn = rstn_q;

  fetch_rsp_buf #(
    .DEPTH (MAX_OUTST),
    .WIDTH (DATA_W)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (kill),
    .push_i (rsp_live & ~kill),
    .pop_i  (inst_fifo_wen),
    .data_i (cache.i_p_readdata),
    .data_o (inst_fifo_r),
    .cnt_o  (buf_cnt)
  );

  // next in-flight and stale-drop counts; kill moves live reads to drop
  always_comb begin
    outst_d = outst_q + CW'(accept) - CW'(rsp_live);
    drop_d  = drop_q - DW'(dropping);
    if (kill) begin
      outst_d = '0;
      drop_d  = drop_q - DW'(dropping)
              + DW'(outst_q) - DW'(rsp_live);
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // RUN/DRAIN tracking and registered instruction FIFO clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rstn_q  <= 1'b0;
    end else begin
      rstn_q <= ~kill;
      unique case (1'b1)
        state_q == RUN:
          if (kill && drop_d != '0) state_q <= DRAIN;
        state_q == DRAIN:
          if (drop_d == '0) state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_cache_mo.sv
// Scoreboard bench for fetch_cache_mo.
// Cache/FIFO models drive inputs; monitor checks written words.
module tb_fetch_cache_mo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0;
  logic        flush = 1'b0;
  logic        jtag = 1'b0;
  logic [31:0] afr = 32'h0;
  logic        afe = 1'b1;
  logic        afren;
  logic        full = 1'b0;
  logic [31:0] ifr;
  logic        ifwen;
  logic        ifrstn;

  fetch_cache_mo_if #(.DATA_W(32), .CACHE_ADDR_W(25)) bus ();

  fetch_cache_mo #(
    .DATA_W(32), .ADDR_W(32), .CACHE_ADDR_W(25),
    .IDX_W(21), .MAX_OUTST(4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .jump_flag_i       (jump),
    .flush_i           (flush),
    .jtag_reset_flag_i (jtag),
    .cache             (bus),
    .addr_fifo_r       (afr),
    .addr_fifo_empty   (afe),
    .addr_fifo_ren     (afren),
    .inst_fifo_full    (full),
    .inst_fifo_r       (ifr),
    .inst_fifo_wen     (ifwen),
    .inst_fifo_rstn    (ifrstn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          due;
  } rsp_t;

  logic [31:0] afq [$];
  rsp_t        pend [$];
  logic [31:0] exp_q [$];
  int cyc = 0;
  int lat = 1;
  int maxinf = 0;
  int total = 0;
  int passed = 0;
  bit hold = 1'b0;

  function automatic logic [31:0] dval(input logic [24:0] a);
    return 32'hC0DE_0000 ^ {7'd0, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pcs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) afq.push_back(base + 32'(4 * i));
  endtask

  task automatic expect_words(input logic [24:0] a0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(dval(a0 + 25'(i)));
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0 || afq.size() != 0)
           && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || pend.size() != 0 || afq.size() != 0) begin
      total++;
      $display("FAIL %s timeout: got %0d words pending expected 0",
               nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // cache and address FIFO drivers, updated after each edge
  always @(posedge clk) begin
    #2;
    cyc++;
    afe = (afq.size() == 0);
    afr = afe ? 32'h0 : afq[0];
    if (rst_n && !hold && pend.size() != 0 && pend[0].due <= cyc) begin
      bus.i_p_readdata_valid = 1'b1;
      bus.i_p_readdata       = pend[0].d;
    end else begin
      bus.i_p_readdata_valid = 1'b0;
      bus.i_p_readdata       = 32'h0;
    end
  end

  // record what the coming edge consumes and accepts
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (bus.i_p_readdata_valid && pend.size() != 0) pend.delete(0);
      if (afren && afq.size() != 0) afq.delete(0);
      if (bus.o_p_read && !bus.i_p_waitrequest)
        pend.push_back('{dval(bus.o_p_addr), cyc + lat});
      if (pend.size() > maxinf) maxinf = pend.size();
    end
  end

  // scoreboard monitor on instruction FIFO writes
  always @(negedge clk) begin
    if (rst_n && ifwen) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got %h expected none", ifr);
      end else begin
        chk("inst_word", ifr, exp_q[0]);
        exp_q.delete(0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.i_p_readdata       = 32'h0;
    bus.i_p_readdata_valid = 1'b0;
    bus.i_p_waitrequest    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rstn", 32'(ifrstn), 0);
    chk("rst_read", 32'(bus.o_p_read), 0);
    chk("rst_wen", 32'(ifwen), 0);
    chk("rst_ren", 32'(afren), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstn_release", 32'(ifrstn), 1);

    // streaming, 1-cycle cache
    step();
    push_pcs(32'h0, 16);
    expect_words(25'h0, 16);
    wait_idle("stream", 200);

    // deep latency: in-flight capped at 4
    lat = 6;
    maxinf = 0;
    step();
    push_pcs(32'h40, 8);
    expect_words(25'h10, 8);
    wait_idle("deep", 300);
    chk("max_inflight", 32'(maxinf), 4);
    lat = 1;

    // backpressure
    full = 1'b1;
    push_pcs(32'h80, 8);
    expect_words(25'h20, 8);
    repeat (10) @(negedge clk);
    chk("bp_read", 32'(bus.o_p_read), 0);
    chk("bp_issued", 32'(afq.size()), 4);
    chk("bp_wen", 32'(ifwen), 0);
    step();
    full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_burst_wen", 32'(ifwen), 1);
    end
    wait_idle("bp", 200);

    // wait-request hold
    bus.i_p_waitrequest = 1'b1;
    afq.push_back(32'h100);
    exp_q.push_back(dval(25'h40));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_read", 32'(bus.o_p_read), 1);
      chk("wr_addr", 32'(bus.o_p_addr), 32'h40);
      chk("wr_ren", 32'(afren), 0);
    end
    step();
    bus.i_p_waitrequest = 1'b0;
    wait_idle("wr", 100);

    // jump with 3 in flight
    hold = 1'b1;
    push_pcs(32'h200, 3);
    repeat (6) step();
    chk("j_inflight", 32'(pend.size()), 3);
    jump = 1'b1;
    afq.push_back(32'h300);
    exp_q.push_back(dval(25'hC0));
    step();
    jump = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("j_rstn_low", 32'(ifrstn), 0);
    @(negedge clk);
    chk("j_rstn_high", 32'(ifrstn), 1);
    wait_idle("jump", 100);

    // kill with response in same cycle, then kill in DRAIN
    hold = 1'b1;
    push_pcs(32'h400, 4);
    repeat (6) step();
    chk("k_inflight", 32'(pend.size()), 4);
    flush = 1'b1;
    hold = 1'b0;
    step();
    flush = 1'b0;
    hold = 1'b1;
    afq.push_back(32'h500);
    @(negedge clk);
    chk("k_rstn_low", 32'(ifrstn), 0);
    chk("k_one_rsp", 32'(pend.size()), 3);
    repeat (3) step();
    chk("k2_inflight", 32'(pend.size()), 4);
    jtag = 1'b1;
    step();
    jtag = 1'b0;
    afq.push_back(32'h600);
    exp_q.push_back(dval(25'h180));
    hold = 1'b0;
    @(negedge clk);
    chk("k2_rstn_low", 32'(ifrstn), 0);
    wait_idle("kill2", 100);

    // async reset mid-stream with 2 in flight
    hold = 1'b1;
    push_pcs(32'h700, 2);
    repeat (4) step();
    chk("ar_inflight", 32'(pend.size()), 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    hold = 1'b0;
    #1;
    chk("ar_rstn", 32'(ifrstn), 0);
    chk("ar_read", 32'(bus.o_p_read), 0);
    chk("ar_wen", 32'(ifwen), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_rstn_release", 32'(ifrstn), 1);
    step();
    full = 1'b1;
    push_pcs(32'h800, 6);
    expect_words(25'h200, 6);
    repeat (8) @(negedge clk);
    chk("ar_outst_clear", 32'(afq.size()), 2);
    step();
    full = 1'b0;
    wait_idle("post_reset", 200);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
